// File: rtl/cordic_atan2_mag_if.sv
`default_nettype none
// ============================================================================
// Interface : cordic_atan2_mag_if
// Purpose   : Start/busy/done handshake and data bundle for the vectoring
//             CORDIC (x,y -> phase, magnitude).
// Signals   : start      - request, sampled only while the engine is idle
//             x_in/y_in  - signed Q2.14 Cartesian input
//             busy       - high from the accept cycle until done
//             done       - one-cycle result strobe
//             angle_rad  - signed Q3.14 radians, (-pi, +pi]
//             angle_deg  - signed integer degrees, (-180, +180]
//             magnitude  - unsigned Q4.14 vector length
//             zero_vec   - input vector was (0,0)
// Modports  : master (requester side), slave (CORDIC engine side)
// Revision  : 1.0 - initial release
// ============================================================================
interface cordic_atan2_mag_if;
  logic               start;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               busy;
  logic               done;
  logic signed [17:0] angle_rad;
  logic signed [15:0] angle_deg;
  logic        [17:0] magnitude;
  logic               zero_vec;

  modport master (
    output start, x_in, y_in,
    input  busy, done, angle_rad, angle_deg, magnitude, zero_vec
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, angle_rad, angle_deg, magnitude, zero_vec
  );
endinterface
`default_nettype wire

// File: rtl/cordic_atan2_mag.sv
`default_nettype none
// ============================================================================
// Module    : cordic_atan2_mag
// Purpose   : Iterative vectoring-mode CORDIC. Converts a Q2.14 (x,y) pair
//             into a Q3.14 phase, integer degrees and a Q4.14 magnitude,
//             one micro-rotation per clock, start/busy/done handshake.
// Ports     : clk    - clock, all logic on posedge
//             reset  - synchronous active-high reset (aborts any operation)
//             bus    - cordic_atan2_mag_if.slave handshake/data bundle
// Params    : ITER     - number of micro-rotations (1..16)
//             GAIN_Q14 - 1/K gain compensation factor, Q2.14
// Macro     : CORDIC_GAIN_COMP_EN - when defined, magnitude is multiplied by
//             GAIN_Q14 in a pipelined two-cycle POST (latency ITER+2);
//             otherwise magnitude is the raw K-scaled x and POST takes one
//             cycle (latency ITER+1).
// Revision  : 1.0 - initial release
// ============================================================================
module cordic_atan2_mag #(
  parameter int          ITER     = 16,
  parameter logic [15:0] GAIN_Q14 = 16'h26DD
) (
  input logic               clk,
  input logic               reset,
  cordic_atan2_mag_if.slave bus
);

  localparam logic signed [17:0] C_PI      = 18'sd51472;   // pi in Q3.14
  localparam logic signed [17:0] C_RAD_MIN = -18'sd51471;  // -pi + 1 LSB

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_POST = 2'd2
  } state_t;

  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'h3244;
      4'd1:    atan_lut = 16'h1DAC;
      4'd2:    atan_lut = 16'h0FAE;
      4'd3:    atan_lut = 16'h07F5;
      4'd4:    atan_lut = 16'h03FF;
      4'd5:    atan_lut = 16'h0200;
      4'd6:    atan_lut = 16'h0100;
      4'd7:    atan_lut = 16'h0080;
      4'd8:    atan_lut = 16'h0040;
      4'd9:    atan_lut = 16'h0020;
      4'd10:   atan_lut = 16'h0010;
      4'd11:   atan_lut = 16'h0008;
      4'd12:   atan_lut = 16'h0004;
      4'd13:   atan_lut = 16'h0002;
      4'd14:   atan_lut = 16'h0001;
      default: atan_lut = 16'h0000;
    endcase
  endfunction

  state_t             state_q;
  logic signed [18:0] x_q, y_q;
  logic signed [17:0] z_q;
  logic        [4:0]  i_q;
  logic               zero_q;
  logic               busy_q, done_q, zvec_q;
  logic signed [17:0] rad_q;
  logic signed [15:0] deg_q;
  logic        [17:0] mag_q;

  // ---------------- pre-rotation into the right half plane ----------------
  logic signed [18:0] x_ext, y_ext, x_pre_d, y_pre_d;
  logic signed [17:0] z_pre_d;
  assign x_ext = {{3{bus.x_in[15]}}, bus.x_in};
  assign y_ext = {{3{bus.y_in[15]}}, bus.y_in};

  always_comb begin
    x_pre_d = x_ext;
    y_pre_d = y_ext;
    z_pre_d = 18'sd0;
    if (bus.x_in[15]) begin
      x_pre_d = -x_ext;
      y_pre_d = -y_ext;
      // y_in == 0 maps to +pi so the result never lands on -pi
      z_pre_d = bus.y_in[15] ? -C_PI : C_PI;
    end
  end

  // ---------------- one micro-rotation ----------------
  logic signed [18:0] x_sh, y_sh, x_d, y_d;
  logic signed [17:0] atan_v, z_d;
  assign x_sh   = x_q >>> i_q;
  assign y_sh   = y_q >>> i_q;
  assign atan_v = $signed({2'b00, atan_lut(i_q[3:0])});

  always_comb begin
    if (!y_q[18]) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_v;
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_v;
    end
  end

  // ---------------- POST: clamp, degree conversion, magnitude ----------------
  logic signed [17:0] z_cl;
  logic signed [31:0] z_ext, deg_prod, deg_sh;
  logic signed [15:0] deg_d;

  always_comb begin
    if (z_q > C_PI)            z_cl = C_PI;
    else if (z_q < C_RAD_MIN)  z_cl = C_RAD_MIN;
    else                       z_cl = z_q;
  end

  // 3667 / 2^20 ~= 180 / (pi * 2^14); +2^19 rounds to nearest degree
  assign z_ext    = {{14{z_cl[17]}}, z_cl};
  assign deg_prod = z_ext * 32'sd3667 + 32'sd524288;
  assign deg_sh   = deg_prod >>> 20;
  assign deg_d    = (deg_sh == -32'sd180) ? 16'sd180 : deg_sh[15:0];

  logic signed [35:0] mag_src;
  logic        [17:0] mag_sat;
  logic               post_last;

`ifdef CORDIC_GAIN_COMP_EN
  // Multiplier result is registered in the first POST cycle; outputs and done
  // follow in the second so the published results never change before done.
  logic signed [35:0] x_w36, g_w36, mul_d, prod_q;
  logic               post_ph_q;
  assign x_w36 = {{17{x_q[18]}}, x_q};
  assign g_w36 = $signed({20'd0, GAIN_Q14});
  assign mul_d = x_w36 * g_w36;

  always_ff @(posedge clk) begin
    if (reset) begin
      post_ph_q <= 1'b0;
      prod_q    <= 36'sd0;
    end else if (state_q == S_POST) begin
      post_ph_q <= ~post_ph_q;
      prod_q    <= mul_d;
    end else begin
      post_ph_q <= 1'b0;
    end
  end

  assign post_last = post_ph_q;
  assign mag_src   = prod_q >>> 14;
`else
  assign post_last = 1'b1;
  assign mag_src   = {{17{x_q[18]}}, x_q};
`endif

  always_comb begin
    if (mag_src < 36'sd0)           mag_sat = 18'd0;
    else if (mag_src > 36'sd262143) mag_sat = 18'h3FFFF;
    else                            mag_sat = mag_src[17:0];
  end

  // ---------------- control FSM with registered outputs ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= 19'sd0;
      y_q     <= 19'sd0;
      z_q     <= 18'sd0;
      i_q     <= 5'd0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zvec_q  <= 1'b0;
      rad_q   <= 18'sd0;
      deg_q   <= 16'sd0;
      mag_q   <= 18'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x_q     <= x_pre_d;
            y_q     <= y_pre_d;
            z_q     <= z_pre_d;
            zero_q  <= (bus.x_in == 16'sd0) && (bus.y_in == 16'sd0);
            i_q     <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + 5'd1;
          if (i_q == 5'(ITER - 1)) state_q <= S_POST;
        end
        S_POST: begin
          if (post_last) begin
            rad_q   <= zero_q ? 18'sd0 : z_cl;
            deg_q   <= zero_q ? 16'sd0 : deg_d;
            mag_q   <= zero_q ? 18'd0  : mag_sat;
            zvec_q  <= zero_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.angle_rad = rad_q;
  assign bus.angle_deg = deg_q;
  assign bus.magnitude = mag_q;
  assign bus.zero_vec  = zvec_q;

endmodule
`default_nettype wire
